// File: rtl/pacing_pkg.sv
// Shared types, q_push_data field layout and drop-counter helpers for pacing_scheduler.
package pacing_pkg;

  typedef enum logic {StIdle, StPush} state_e;

  // q_push_data = {timestamp, pacing vector}; pacing bits sit at the bottom
  localparam int unsigned PACING_LSB = 0;
  localparam int unsigned DROP_W     = 16;
  // Widest per-cycle drop increment: up to 16 streams can drop at once
  localparam int unsigned DROP_INC_W = 5;

  // Timestamp field starts right above the pacing vector
  function automatic int unsigned ts_lsb(int unsigned num_streams);
    return num_streams;
  endfunction

  // Saturating add used for the dropped-deadline counter
  function automatic logic [DROP_W-1:0] sat_add(logic [DROP_W-1:0] a,
                                                logic [DROP_INC_W-1:0] b);
    logic [DROP_W:0] sum;
    sum = {1'b0, a} + {{(DROP_W + 1 - DROP_INC_W){1'b0}}, b};
    return sum[DROP_W] ? {DROP_W{1'b1}} : sum[DROP_W-1:0];
  endfunction

endpackage

// File: rtl/pacing_scheduler_period_counter.sv
// Per-stream period down-counter: flags 'due' when it reaches zero on an enabled tick.
module period_counter
  import pacing_pkg::*;
#(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [CNT_W-1:0] period,
  output logic             due
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Due on the tick the counter sits at zero; reload or count down only while enabled
  always_comb begin
    due   = en && (cnt_q == '0);
    cnt_d = cnt_q;
    if (due) begin
      cnt_d = period - CNT_W'(1);
    end else if (en) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  // Counter register; reset loads period-1 so the first due lands on ts=period-1
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= period - CNT_W'(1);
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/pacing_scheduler.sv
// Periodic-stream scheduler: bundles streams due on the same tick into timestamped queue entries.
module pacing_scheduler
  import pacing_pkg::*;
#(
  parameter int unsigned                     NUM_STREAMS = 2,
  parameter int unsigned                     CNT_W       = 32,
  parameter int unsigned                     TS_W        = 64,
  parameter logic [NUM_STREAMS*CNT_W-1:0]    PERIODS     = {32'd2000, 32'd1000}
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        en,
  input  logic                        q_ready,
  output logic                        q_push,
  output logic [TS_W+NUM_STREAMS-1:0] q_push_data,
  output logic [NUM_STREAMS-1:0]      pacing,
  output logic [TS_W-1:0]             ts,
  output logic                        overflow,
  output logic [DROP_W-1:0]           drop_count
);

  localparam int unsigned TS_LSB = ts_lsb(NUM_STREAMS);
  localparam int unsigned DW     = TS_W + NUM_STREAMS;

  logic [NUM_STREAMS-1:0] due;

  for (genvar g = 0; g < NUM_STREAMS; g++) begin : g_cnt
    period_counter #(
      .CNT_W (CNT_W)
    ) u_cnt (
      .clk    (clk),
      .rst    (rst),
      .en     (en),
      .period (PERIODS[g*CNT_W +: CNT_W]),
      .due    (due[g])
    );
  end

  state_e                 state_q, state_d;
  logic [TS_W-1:0]        ts_q, ts_d;
  logic [NUM_STREAMS-1:0] pending_q, pending_d;
  logic [TS_W-1:0]        pend_ts_q, pend_ts_d;
  logic [DW-1:0]          push_data_q, push_data_d;
  logic [NUM_STREAMS-1:0] pacing_q, pacing_d;
  logic                   overflow_q, overflow_d;
  logic [DROP_W-1:0]      drop_cnt_q, drop_cnt_d;

  logic                   handshake;
  logic                   slot_free;
  logic [NUM_STREAMS-1:0] merged;
  logic [NUM_STREAMS-1:0] drops;
  logic [DROP_INC_W-1:0]  drop_inc;

  // Next-state: time base, drop accounting, merge register and push FSM
  always_comb begin
    ts_d = en ? ts_q + TS_W'(1) : ts_q;

    // A stream due again while its previous deadline is still only pending has lost one
    drops    = due & pending_q;
    drop_inc = '0;
    for (int i = 0; i < NUM_STREAMS; i++) begin
      drop_inc = drop_inc + DROP_INC_W'(drops[i]);
    end
    overflow_d = overflow_q | (|drops);
    drop_cnt_d = sat_add(drop_cnt_q, drop_inc);

    handshake = (state_q == StPush) && q_ready;
    // The output register can take a new entry when idle or when its entry leaves this cycle
    slot_free = (state_q == StIdle) || handshake;
    merged    = pending_q | due;
    pacing_d  = handshake ? push_data_q[PACING_LSB +: NUM_STREAMS] : '0;

    state_d     = state_q;
    push_data_d = push_data_q;
    pending_d   = pending_q;
    pend_ts_d   = pend_ts_q;

    if (slot_free) begin
      if (|merged) begin
        state_d                              = StPush;
        push_data_d[TS_LSB +: TS_W]          = (|pending_q) ? pend_ts_q : ts_q;
        push_data_d[PACING_LSB +: NUM_STREAMS] = merged;
        pending_d                            = '0;
      end else begin
        state_d = StIdle;
      end
    end else begin
      pending_d = merged;
      // Tag the merged entry with the oldest deadline it carries
      if (!(|pending_q) && (|due)) begin
        pend_ts_d = ts_q;
      end
    end
  end

  // State registers; synchronous reset discards any entry in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      ts_q        <= '0;
      pending_q   <= '0;
      pend_ts_q   <= '0;
      push_data_q <= '0;
      pacing_q    <= '0;
      overflow_q  <= 1'b0;
      drop_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      ts_q        <= ts_d;
      pending_q   <= pending_d;
      pend_ts_q   <= pend_ts_d;
      push_data_q <= push_data_d;
      pacing_q    <= pacing_d;
      overflow_q  <= overflow_d;
      drop_cnt_q  <= drop_cnt_d;
    end
  end

  assign q_push      = (state_q == StPush);
  assign q_push_data = push_data_q;
  assign pacing      = pacing_q;
  assign ts          = ts_q;
  assign overflow    = overflow_q;
  assign drop_count  = drop_cnt_q;

endmodule

// File: tb/tb_pacing_scheduler.sv
// Bench for pacing_scheduler: cycle-level reference model plus directed literal checks.
module tb_pacing_scheduler;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance A: TS_W=64, PERIODS={5,3}
  logic        rst_a = 1'b1, en_a = 1'b1, rdy_a = 1'b1;
  logic        q_push_a, ovf_a;
  logic [65:0] data_a;
  logic [1:0]  pac_a;
  logic [63:0] ts_a;
  logic [15:0] drop_a;

  pacing_scheduler #(
    .NUM_STREAMS (2),
    .CNT_W       (32),
    .TS_W        (64),
    .PERIODS     ({32'd5, 32'd3})
  ) dut_a (
    .clk         (clk),
    .rst         (rst_a),
    .en          (en_a),
    .q_ready     (rdy_a),
    .q_push      (q_push_a),
    .q_push_data (data_a),
    .pacing      (pac_a),
    .ts          (ts_a),
    .overflow    (ovf_a),
    .drop_count  (drop_a)
  );

  // Instance B: TS_W=4, PERIODS={16,1}
  logic       rst_b = 1'b1, en_b = 1'b0, rdy_b = 1'b0;
  logic       q_push_b, ovf_b;
  logic [5:0] data_b;
  logic [1:0] pac_b;
  logic [3:0] ts_b;
  logic [15:0] drop_b;

  pacing_scheduler #(
    .NUM_STREAMS (2),
    .CNT_W       (32),
    .TS_W        (4),
    .PERIODS     ({32'd16, 32'd1})
  ) dut_b (
    .clk         (clk),
    .rst         (rst_b),
    .en          (en_b),
    .q_ready     (rdy_b),
    .q_push      (q_push_b),
    .q_push_data (data_b),
    .pacing      (pac_b),
    .ts          (ts_b),
    .overflow    (ovf_b),
    .drop_count  (drop_b)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: time is a count of enabled ticks since reset; stream i is due on the
  // tick whose pre-increment count c satisfies (c+1) % P_i == 0.
  typedef struct {
    longint ticks;
    bit     push;
    longint dts;
    bit [1:0] dbits;
    bit [1:0] pend;
    longint pts;
    bit [1:0] pac;
    bit     ovf;
    int     drops;
  } mstate_t;

  function automatic mstate_t zero_state();
    mstate_t s;
    s.ticks = 0; s.push = 0; s.dts = 0; s.dbits = 0; s.pend = 0;
    s.pts = 0; s.pac = 0; s.ovf = 0; s.drops = 0;
    return s;
  endfunction

  function automatic mstate_t step(mstate_t s, bit r, bit e, bit rdy, longint p0, longint p1,
                                   longint tsmod);
    mstate_t n;
    bit [1:0] due, lost, all;
    bit accept, slot;
    longint cur;
    n = s;
    if (r) return zero_state();
    cur = s.ticks % tsmod;
    due = 2'b00;
    if (e) begin
      due[0] = ((s.ticks + 1) % p0) == 0;
      due[1] = ((s.ticks + 1) % p1) == 0;
      n.ticks = s.ticks + 1;
    end
    lost = due & s.pend;
    n.drops = s.drops + int'(lost[0]) + int'(lost[1]);
    if (n.drops > 65535) n.drops = 65535;
    if (lost != 0) n.ovf = 1;
    accept = s.push && rdy;
    n.pac  = accept ? s.dbits : 2'b00;
    slot   = !s.push || accept;
    all    = s.pend | due;
    if (slot) begin
      if (all != 0) begin
        n.push = 1; n.dbits = all; n.pend = 0;
        n.dts  = (s.pend != 0) ? s.pts : cur;
      end else begin
        n.push = 0;
      end
    end else begin
      n.pend = all;
      if (s.pend == 0 && due != 0) n.pts = cur;
    end
    return n;
  endfunction

  localparam longint MODA = 64'h0000_0100_0000_0000;
  localparam longint MODB = 16;

  mstate_t ma, mb;
  bit started = 0;

  always @(posedge clk) begin
    ma = step(ma, rst_a, en_a, rdy_a, 3, 5, MODA);
    mb = step(mb, rst_b, en_b, rdy_b, 1, 16, MODB);
    started = 1;
  end

  typedef struct { longint ts; int bits; } entry_t;
  entry_t log_a[$];
  entry_t log_b[$];
  bit          prev_push_a = 0, prev_push_b = 0;
  logic [65:0] prev_data_a = '0;
  logic [5:0]  prev_data_b = '0;

  // Compare against the model every cycle; log accepted entries from the pacing pulse
  always @(negedge clk) begin
    if (started) begin
      chk("A_ts", ts_a, 64'(ma.ticks % MODA));
      chk("A_q_push", 64'(q_push_a), 64'(ma.push));
      if (ma.push) begin
        chk("A_data_ts", data_a[65:2], 64'(ma.dts));
        chk("A_data_bits", 64'(data_a[1:0]), 64'(ma.dbits));
      end
      chk("A_pacing", 64'(pac_a), 64'(ma.pac));
      chk("A_overflow", 64'(ovf_a), 64'(ma.ovf));
      chk("A_drop_count", 64'(drop_a), 64'(ma.drops));
      chk("B_ts", 64'(ts_b), 64'(mb.ticks % MODB));
      chk("B_q_push", 64'(q_push_b), 64'(mb.push));
      if (mb.push) begin
        chk("B_data_ts", 64'(data_b[5:2]), 64'(mb.dts));
        chk("B_data_bits", 64'(data_b[1:0]), 64'(mb.dbits));
      end
      chk("B_pacing", 64'(pac_b), 64'(mb.pac));
      chk("B_overflow", 64'(ovf_b), 64'(mb.ovf));
      chk("B_drop_count", 64'(drop_b), 64'(mb.drops));
      if (pac_a != 0 && prev_push_a) log_a.push_back('{longint'(prev_data_a[65:2]),
                                                        int'(prev_data_a[1:0])});
      if (pac_b != 0 && prev_push_b) log_b.push_back('{longint'(prev_data_b[5:2]),
                                                        int'(prev_data_b[1:0])});
    end
    prev_push_a = q_push_a; prev_data_a = data_a;
    prev_push_b = q_push_b; prev_data_b = data_b;
  end

  task automatic drive_a(input bit r, input bit e, input bit rdy, input int n);
    rst_a = r; en_a = e; rdy_a = rdy;
    repeat (n) begin @(negedge clk); #1; end
  endtask

  task automatic drive_b(input bit r, input bit e, input bit rdy, input int n);
    rst_b = r; en_b = e; rdy_b = rdy;
    repeat (n) begin @(negedge clk); #1; end
  endtask

  task automatic chk_log_a(input int idx, input longint ets, input int ebits);
    chk("A_log_present", 64'(log_a.size() > idx), 64'd1);
    if (log_a.size() > idx) begin
      chk("A_log_ts", 64'(log_a[idx].ts), 64'(ets));
      chk("A_log_bits", 64'(log_a[idx].bits), 64'(ebits));
    end
  endtask

  task automatic chk_log_b(input int idx, input longint ets, input int ebits);
    chk("B_log_present", 64'(log_b.size() > idx), 64'd1);
    if (log_b.size() > idx) begin
      chk("B_log_ts", 64'(log_b[idx].ts), 64'(ets));
      chk("B_log_bits", 64'(log_b[idx].bits), 64'(ebits));
    end
  endtask

  initial begin
    ma = zero_state();
    mb = zero_state();

    // Reset held with en=1: nothing moves
    drive_a(1, 1, 1, 4);
    chk("T1_ts", ts_a, 64'd0);
    chk("T1_q_push", 64'(q_push_a), 64'd0);
    chk("T1_drop", 64'(drop_a), 64'd0);

    // Free run
    log_a.delete();
    drive_a(0, 1, 1, 17);
    chk("T2_log_size", 64'(log_a.size()), 64'd7);
    chk_log_a(0, 2, 1);
    chk_log_a(1, 4, 2);
    chk_log_a(2, 5, 1);
    chk_log_a(3, 8, 1);
    chk_log_a(4, 9, 2);
    chk_log_a(5, 11, 1);
    chk_log_a(6, 14, 3);
    chk("T2_overflow", 64'(ovf_a), 64'd0);

    // Backpressure for ts 0..7, released from ts 8
    drive_a(1, 1, 1, 1);
    log_a.delete();
    for (int k = 0; k < 12; k++) drive_a(0, 1, (k >= 8), 1);
    chk_log_a(0, 2, 1);
    chk_log_a(1, 4, 3);
    chk_log_a(2, 9, 2);
    chk("T3_overflow", 64'(ovf_a), 64'd1);
    chk("T3_drop", 64'(drop_a), 64'd1);

    // Freeze time with an entry in flight
    drive_a(1, 1, 1, 1);
    log_a.delete();
    drive_a(0, 1, 1, 6);
    drive_a(0, 0, 0, 3);
    drive_a(0, 0, 1, 7);
    chk("T4_ts_frozen", ts_a, 64'd6);
    drive_a(0, 1, 1, 7);
    chk_log_a(0, 2, 1);
    chk_log_a(1, 4, 2);
    chk_log_a(2, 5, 1);
    chk_log_a(3, 8, 1);
    chk_log_a(4, 9, 2);

    // Reset while a push is in flight and pending is non-empty
    drive_a(1, 1, 1, 1);
    drive_a(0, 1, 0, 6);
    chk("T5_push_before", 64'(q_push_a), 64'd1);
    drive_a(1, 1, 0, 1);
    chk("T5_q_push", 64'(q_push_a), 64'd0);
    chk("T5_ts", ts_a, 64'd0);
    chk("T5_data", data_a[63:0], 64'd0);
    log_a.delete();
    drive_a(0, 1, 1, 5);
    chk_log_a(0, 2, 1);

    // Narrow timestamp wrap with a period-1 stream
    drive_a(1, 1, 1, 1);
    drive_b(1, 1, 1, 2);
    log_b.delete();
    drive_b(0, 1, 1, 20);
    chk_log_b(14, 14, 1);
    chk_log_b(15, 15, 3);
    chk_log_b(16, 0, 1);
    chk_log_b(17, 1, 1);
    chk("T6_drop", 64'(drop_b), 64'd0);
    chk("T6_overflow", 64'(ovf_b), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
